// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared states, status/mode codes, frame offsets and key-size helpers for the AES SPI controller
package aes_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, DECODE, EXPAND, CRYPT, RESP} state_t;
  localparam logic [7:0] ST_OK = 8'h00;
  localparam logic [7:0] ST_BAD_KEYLEN = 8'h01;
  localparam logic [7:0] ST_BAD_MODE = 8'h02;
  localparam logic [7:0] ST_TIMEOUT = 8'h03;
  localparam logic [7:0] MODE_ENC = 8'h00;
  localparam logic [7:0] MODE_DEC = 8'h01;
  localparam int OFS_BLOCK = 1;
  localparam int OFS_MODE = 129;
  localparam int OFS_KEYLEN = 137;
  localparam int OFS_KEY = 145;
  function automatic logic [3:0] keylen_to_nk(input logic [7:0] kl);
    return kl == 8'd16 ? 4'd4 : kl == 8'd24 ? 4'd6 : kl == 8'd32 ? 4'd8 : 4'd0;
  endfunction
  function automatic logic [3:0] keylen_to_nr(input logic [7:0] kl);
    return kl == 8'd16 ? 4'd10 : kl == 8'd24 ? 4'd12 : kl == 8'd32 ? 4'd14 : 4'd0;
  endfunction
  function automatic logic [255:0] mask_key(input logic [255:0] key, input logic [3:0] nk);
    return key & ({256{1'b1}} << (9'd256 - {nk, 5'd0}));
  endfunction
endpackage

// File: rtl/aes_key_cache.sv
// aes_key_cache: last expanded key/NK with valid bit; ports clk, reset, load, invalidate, key, nk in; combinational hit out
module aes_key_cache (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         invalidate,
  input  logic [255:0] key,
  input  logic [3:0]   nk,
  output logic         hit
);
  logic [255:0] key_r;
  logic [3:0] nk_r;
  logic valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_r <= '0;
      nk_r <= '0;
      valid <= 1'b0;
    end else if (invalidate) begin
      valid <= 1'b0;
    end else if (load) begin
      key_r <= key;
      nk_r <= nk;
      valid <= 1'b1;
    end
  end
  assign hit = valid && key == key_r && nk == nk_r;
endmodule

// File: rtl/aes_spi_ctrl.sv
// aes_spi_ctrl: AES front-end sequencer; rx frame in (valid/ready), key-expansion and cipher start/done out/in, status+result tx out (valid/ready), busy
module aes_spi_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int FRAME_W = 400,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CACHE_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [FRAME_W-1:0] rx_frame,
  output logic               ke_start,
  output logic [255:0]       ke_key,
  output logic [3:0]         ke_nk,
  input  logic               ke_done,
  output logic               core_start,
  output logic               core_decrypt,
  output logic [3:0]         core_nr,
  output logic [127:0]       core_block,
  input  logic               core_done,
  input  logic [127:0]       core_result,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [135:0]       tx_frame,
  output logic               busy
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  state_t state;
  logic [127:0] block_q, data_q;
  logic [255:0] key_m, f_key;
  logic [7:0] status_q, f_mode, f_kl;
  logic [3:0] nk_q, nr_q, f_nk;
  logic decrypt_q, bad_mode, hit, ke_ok, tmo, c_load, c_inv;
  logic [CW-1:0] cnt;
  assign f_mode = rx_frame[FRAME_W-OFS_MODE -: 8];
  assign f_kl = rx_frame[FRAME_W-OFS_KEYLEN -: 8];
  assign f_key = rx_frame[FRAME_W-OFS_KEY -: 256];
  assign f_nk = keylen_to_nk(f_kl);
  assign rx_ready = state == IDLE;
  assign busy = state != IDLE;
  assign ke_key = key_m;
  assign ke_nk = nk_q;
  assign core_decrypt = decrypt_q;
  assign core_nr = nr_q;
  assign core_block = block_q;
  assign tx_frame = {status_q, data_q};
  assign ke_ok = ke_done && !ke_start;
  assign tmo = cnt == CW'(TIMEOUT_CYC - 1);
  assign c_load = state == EXPAND && ke_ok;
  assign c_inv = tmo && ((state == EXPAND && !ke_ok) || (state == CRYPT && !core_done));
  aes_key_cache u_cache (
    .clk(clk),
    .reset(reset),
    .load(c_load),
    .invalidate(c_inv),
    .key(key_m),
    .nk(nk_q),
    .hit(hit)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      block_q <= '0;
      data_q <= '0;
      key_m <= '0;
      status_q <= '0;
      nk_q <= '0;
      nr_q <= '0;
      decrypt_q <= 1'b0;
      bad_mode <= 1'b0;
      cnt <= '0;
      ke_start <= 1'b0;
      core_start <= 1'b0;
      tx_valid <= 1'b0;
    end else begin
      ke_start <= 1'b0;
      core_start <= 1'b0;
      unique case (state)
        IDLE: if (rx_valid) begin
          block_q <= rx_frame[FRAME_W-OFS_BLOCK -: 128];
          key_m <= mask_key(f_key, f_nk);
          nk_q <= f_nk;
          nr_q <= keylen_to_nr(f_kl);
          decrypt_q <= f_mode == MODE_DEC;
          bad_mode <= f_mode != MODE_ENC && f_mode != MODE_DEC;
          state <= DECODE;
        end
        DECODE: if (nk_q == 4'd0 || bad_mode) begin
          status_q <= nk_q == 4'd0 ? ST_BAD_KEYLEN : ST_BAD_MODE;
          data_q <= '0;
          tx_valid <= 1'b1;
          state <= RESP;
        end else if (CACHE_EN != 0 && hit) begin
          core_start <= 1'b1;
          cnt <= '0;
          state <= CRYPT;
        end else begin
          ke_start <= 1'b1;
          cnt <= '0;
          state <= EXPAND;
        end
        EXPAND: if (ke_ok) begin
          core_start <= 1'b1;
          cnt <= '0;
          state <= CRYPT;
        end else if (tmo) begin
          status_q <= ST_TIMEOUT;
          data_q <= '0;
          tx_valid <= 1'b1;
          state <= RESP;
        end else begin
          cnt <= cnt + CW'(1);
        end
        CRYPT: if (core_done) begin
          status_q <= ST_OK;
          data_q <= core_result;
          tx_valid <= 1'b1;
          state <= RESP;
        end else if (tmo) begin
          status_q <= ST_TIMEOUT;
          data_q <= '0;
          tx_valid <= 1'b1;
          state <= RESP;
        end else begin
          cnt <= cnt + CW'(1);
        end
        RESP: if (tx_ready) begin
          tx_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
